pipe_ex_unit: RTL and testbench

//  Parametrised execute stage. Sits between decode/issue and memory-access. Accepts one op per

---
 rtl/pipe_ex_unit_if.sv | 66 ++++++
 rtl/pipe_ex_unit.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_ex_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ex_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ex_unit_if
// Description : Bundle of issue, forwarding, result, redirect and predictor
//               signals between the execute stage and its neighbours.
//               master = surrounding pipeline, slave = execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ex_unit_if #(
  parameter int XLEN     = 32,
  parameter int NUM_FWD  = 2,
  parameter int BP_TAG_W = 10
);
  // issue side
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         pc_in;
  logic [3:0]              op_in;
  logic [1:0]              kind_in;
  logic [4:0]              rd;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic [XLEN-1:0]         opr1_in;
  logic [XLEN-1:0]         opr2_in;
  logic [XLEN-1:0]         imm_in;
  logic                    mem_e_in;
  logic                    wb_e_in;
  // forwarding channels
  logic [NUM_FWD-1:0]      fwd_en;
  logic [5*NUM_FWD-1:0]    fwd_idx;
  logic [XLEN*NUM_FWD-1:0] fwd_val;
  logic                    flush;
  // result side
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         result;
  logic [XLEN-1:0]         store_val;
  logic [4:0]              rd_out;
  logic                    mem_e_out;
  logic                    wb_e_out;
  // redirect and predictor update
  logic                    redir_valid;
  logic                    redir_ready;
  logic [XLEN-1:0]         redir_pc;
  logic                    bp_we;
  logic [BP_TAG_W-1:0]     bp_tag;
  logic                    bp_taken;
  // bypass back to earlier stages
  logic [4:0]              ex_fwd_idx;
  logic [XLEN-1:0]         ex_fwd_val;

  modport master (
    output in_valid, pc_in, op_in, kind_in, rd, rs1, rs2, opr1_in, opr2_in, imm_in,
           mem_e_in, wb_e_in, fwd_en, fwd_idx, fwd_val, flush, out_ready, redir_ready,
    input  in_ready, out_valid, result, store_val, rd_out, mem_e_out, wb_e_out,
           redir_valid, redir_pc, bp_we, bp_tag, bp_taken, ex_fwd_idx, ex_fwd_val
  );

  modport slave (
    input  in_valid, pc_in, op_in, kind_in, rd, rs1, rs2, opr1_in, opr2_in, imm_in,
           mem_e_in, wb_e_in, fwd_en, fwd_idx, fwd_val, flush, out_ready, redir_ready,
    output in_ready, out_valid, result, store_val, rd_out, mem_e_out, wb_e_out,
           redir_valid, redir_pc, bp_we, bp_tag, bp_taken, ex_fwd_idx, ex_fwd_val
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ex_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ex_unit
// Description : Execute stage. Resolves operands through prioritised
//               forwarding, computes ALU ops (multi-cycle MUL), resolves
//               branches/jumps, drives a held redirect handshake and a
//               one-cycle branch-predictor update.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ex_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_FWD  = 2,
  parameter int BP_TAG_W = 10,
  parameter int MUL_LAT  = 3
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ex_unit_if.slave bus
);
  localparam int         c_SHW   = $clog2(XLEN);
  localparam int         c_CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [1:0] c_K_ALU = 2'd0;
  localparam logic [1:0] c_K_BR  = 2'd1;
  localparam logic [1:0] c_K_JAL = 2'd2;
  localparam logic [3:0] c_OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [XLEN-1:0]      r_mul;
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_result;
  logic [XLEN-1:0]      r_store_val;
  logic [4:0]           r_rd;
  logic                 r_mem_e;
  logic                 r_wb_e;
  logic                 r_redir_valid;
  logic [XLEN-1:0]      r_redir_pc;
  logic                 r_bp_we;
  logic [BP_TAG_W-1:0]  r_bp_tag;
  logic                 r_bp_taken;

  logic [XLEN-1:0]      w_opr1;
  logic [XLEN-1:0]      w_opr2_fwd;
  logic [XLEN-1:0]      w_opr2;
  logic [c_SHW-1:0]     w_sh;
  logic                 w_cmp;
  logic [XLEN-1:0]      w_alu;
  logic [XLEN-1:0]      w_res;
  logic [XLEN-1:0]      w_target;
  logic                 w_redir;
  logic                 w_is_br;
  logic                 w_is_mul;

  // Operand resolution: scan from highest index down so the lowest matching channel wins.
  always_comb begin
    w_opr1     = bus.opr1_in;
    w_opr2_fwd = bus.opr2_in;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (bus.rs1 != 5'd0 && bus.fwd_en[k] && bus.fwd_idx[5*k +: 5] == bus.rs1)
        w_opr1 = bus.fwd_val[XLEN*k +: XLEN];
      if (bus.rs2 != 5'd0 && bus.fwd_en[k] && bus.fwd_idx[5*k +: 5] == bus.rs2)
        w_opr2_fwd = bus.fwd_val[XLEN*k +: XLEN];
    end
  end

  assign w_is_br  = (bus.kind_in == c_K_BR);
  assign w_is_mul = (bus.kind_in == c_K_ALU) && (bus.op_in == c_OP_MUL);
  // Immediate replaces rs2 for plain ALU ops; MUL and branches compare/multiply registers.
  assign w_opr2   = (bus.kind_in == c_K_ALU && bus.op_in != c_OP_MUL) ? bus.imm_in : w_opr2_fwd;
  assign w_sh     = w_opr2[c_SHW-1:0];

  // Comparison shared by SLT/SLTU and the branch conditions.
  always_comb begin
    w_cmp = 1'b0;
    case (bus.op_in)
      4'd3, 4'd13: w_cmp = $signed(w_opr1) < $signed(w_opr2);
      4'd4, 4'd15: w_cmp = w_opr1 < w_opr2;
      4'd11:       w_cmp = w_opr1 == w_opr2;
      4'd12:       w_cmp = w_opr1 != w_opr2;
      4'd14:       w_cmp = $signed(w_opr1) >= $signed(w_opr2);
      default:     w_cmp = 1'b0;
    endcase
  end

  // ALU result selection.
  always_comb begin
    w_alu = '0;
    case (bus.op_in)
      4'd0:    w_alu = w_opr1 + w_opr2;
      4'd1:    w_alu = w_opr1 - w_opr2;
      4'd2:    w_alu = w_opr1 << w_sh;
      4'd5:    w_alu = w_opr1 ^ w_opr2;
      4'd6:    w_alu = w_opr1 >> w_sh;
      4'd7:    w_alu = $unsigned($signed(w_opr1) >>> w_sh);
      4'd8:    w_alu = w_opr1 | w_opr2;
      4'd9:    w_alu = w_opr1 & w_opr2;
      4'd10:   w_alu = w_opr1 * w_opr2;
      default: w_alu = {{(XLEN-1){1'b0}}, w_cmp};
    endcase
  end

  // Per-kind result, redirect target and redirect request.
  always_comb begin
    w_res    = bus.pc_in + XLEN'(4);
    w_target = bus.pc_in + bus.imm_in;
    w_redir  = 1'b1;
    case (bus.kind_in)
      c_K_ALU: begin
        w_res   = w_alu;
        w_redir = 1'b0;
      end
      c_K_BR: begin
        w_res   = '0;
        w_redir = w_cmp;
      end
      c_K_JAL: w_redir = 1'b1;
      default: w_target = (w_opr1 + bus.imm_in) & ~XLEN'(1);
    endcase
  end

  // Control FSM and registered outputs; flush kills everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mul         <= '0;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_store_val   <= '0;
      r_rd          <= '0;
      r_mem_e       <= 1'b0;
      r_wb_e        <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_bp_we       <= 1'b0;
      r_bp_tag      <= '0;
      r_bp_taken    <= 1'b0;
    end else if (bus.flush) begin
      r_state       <= IDLE;
      r_out_valid   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_bp_we       <= 1'b0;
    end else begin
      r_bp_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rd        <= bus.rd;
            r_mem_e     <= bus.mem_e_in;
            r_wb_e      <= bus.wb_e_in && !w_is_br;
            r_store_val <= w_opr2_fwd;
            r_redir_pc  <= w_target;
            r_bp_tag    <= bus.pc_in[BP_TAG_W+1:2];
            r_bp_taken  <= w_is_br && w_cmp;
            if (w_is_mul) begin
              r_mul   <= w_alu;
              r_cnt   <= c_CNT_W'(MUL_LAT - 2);
              r_state <= BUSY;
            end else begin
              r_result      <= w_res;
              r_out_valid   <= 1'b1;
              r_redir_valid <= w_redir;
              r_bp_we       <= w_is_br;
              r_state       <= DONE;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_result    <= r_mul;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready)   r_out_valid   <= 1'b0;
          if (bus.redir_ready) r_redir_valid <= 1'b0;
          if ((!r_out_valid || bus.out_ready) && (!r_redir_valid || bus.redir_ready))
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.store_val   = r_store_val;
  assign bus.rd_out      = r_rd;
  assign bus.mem_e_out   = r_mem_e;
  assign bus.wb_e_out    = r_wb_e;
  assign bus.redir_valid = r_redir_valid;
  assign bus.redir_pc    = r_redir_pc;
  assign bus.bp_we       = r_bp_we;
  assign bus.bp_tag      = r_bp_tag;
  assign bus.bp_taken    = r_bp_taken;
  assign bus.ex_fwd_idx  = (r_out_valid && r_wb_e && !r_mem_e && r_rd != 5'd0) ? r_rd : 5'd0;
  assign bus.ex_fwd_val  = r_result;
endmodule
`default_nettype wire

// File: tb/tb_pipe_ex_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ex_unit
// Description : Self-checking bench for pipe_ex_unit: vector table plus
//               scoreboards for result, redirect and predictor-update traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ex_unit;
  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_JAL = 2'd2, K_JALR = 2'd3;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9, OP_MUL = 4'd10, OP_EQ = 4'd11,
                         OP_NE = 4'd12, OP_LT = 4'd13, OP_GE = 4'd14, OP_LTU = 4'd15;

  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] opr1, opr2, imm;
    logic        wb, mem;
    logic [1:0]  fen;
    logic [9:0]  fidx;
    logic [63:0] fval;
    logic [31:0] exp_res, exp_store;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res, store;
    logic [4:0]  rd, fidx;
    logic        wb, mem;
  } out_exp_t;

  typedef struct {
    int          id;
    logic [9:0]  tag;
    logic        taken;
  } bp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  out_exp_t    out_q[$];
  logic [31:0] redir_q[$];
  bp_exp_t     bp_q[$];
  vec_t        vecs[$];
  out_exp_t    oe;
  bp_exp_t     be;
  logic [31:0] re;
  logic        bp_prev = 1'b0;

  pipe_ex_unit_if #(.XLEN(32), .NUM_FWD(2), .BP_TAG_W(10)) bus ();

  pipe_ex_unit #(.XLEN(32), .NUM_FWD(2), .BP_TAG_W(10), .MUL_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic vec_t mk(input logic [1:0] k, input logic [3:0] op, input logic [31:0] pc,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] imm,
                              input logic wb, input logic mem, input logic [1:0] fen,
                              input logic [9:0] fidx, input logic [63:0] fval,
                              input logic [31:0] er, input logic [31:0] es,
                              input logic rv, input logic [31:0] rp);
    vec_t v;
    v.kind = k; v.op = op; v.pc = pc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.opr1 = o1; v.opr2 = o2; v.imm = imm; v.wb = wb; v.mem = mem;
    v.fen = fen; v.fidx = fidx; v.fval = fval;
    v.exp_res = er; v.exp_store = es; v.exp_redir = rv; v.exp_pc = rp;
    return v;
  endfunction

  // Drive one op, wait for in_ready (bounded) and record the expected traffic.
  task automatic issue(input vec_t v, input int id, input bit push);
    int n;
    out_exp_t e;
    bp_exp_t  b;
    @(negedge clk);
    bus.kind_in = v.kind; bus.op_in = v.op; bus.pc_in = v.pc;
    bus.rd = v.rd; bus.rs1 = v.rs1; bus.rs2 = v.rs2;
    bus.opr1_in = v.opr1; bus.opr2_in = v.opr2; bus.imm_in = v.imm;
    bus.wb_e_in = v.wb; bus.mem_e_in = v.mem;
    bus.fwd_en = v.fen; bus.fwd_idx = v.fidx; bus.fwd_val = v.fval;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail_evt($sformatf("issue%0d_timeout", id));
    else if (push) begin
      e.id = id; e.res = v.exp_res; e.store = v.exp_store; e.rd = v.rd;
      e.wb = v.wb && (v.kind != K_BR); e.mem = v.mem;
      e.fidx = (e.wb && !v.mem && v.rd != 5'd0) ? v.rd : 5'd0;
      out_q.push_back(e);
      if (v.exp_redir) redir_q.push_back(v.exp_pc);
      if (v.kind == K_BR) begin
        b.id = id; b.tag = v.pc[11:2]; b.taken = v.exp_redir;
        bp_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.fwd_en = '0;
  endtask

  // Result scoreboard.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (out_q.size() == 0) fail_evt("unexpected_out");
      else begin
        oe = out_q.pop_front();
        check($sformatf("out%0d_result", oe.id), bus.result, oe.res);
        check($sformatf("out%0d_store", oe.id), bus.store_val, oe.store);
        check($sformatf("out%0d_rd", oe.id), bus.rd_out, oe.rd);
        check($sformatf("out%0d_wb", oe.id), bus.wb_e_out, oe.wb);
        check($sformatf("out%0d_mem", oe.id), bus.mem_e_out, oe.mem);
        check($sformatf("out%0d_fwd_idx", oe.id), bus.ex_fwd_idx, oe.fidx);
        check($sformatf("out%0d_fwd_val", oe.id), bus.ex_fwd_val, oe.res);
      end
    end
  end

  // Redirect scoreboard.
  always @(negedge clk) begin
    if (rst && bus.redir_valid && bus.redir_ready) begin
      if (redir_q.size() == 0) fail_evt("unexpected_redir");
      else begin
        re = redir_q.pop_front();
        check("redir_pc", bus.redir_pc, re);
      end
    end
  end

  // Predictor-update scoreboard; strobe must never last two cycles.
  always @(negedge clk) begin
    if (rst && bus.bp_we) begin
      check("bp_we_width", bp_prev, 1'b0);
      if (bp_q.size() == 0) fail_evt("unexpected_bp_we");
      else begin
        be = bp_q.pop_front();
        check($sformatf("bp%0d_tag", be.id), bus.bp_tag, be.tag);
        check($sformatf("bp%0d_taken", be.id), bus.bp_taken, be.taken);
      end
    end
    bp_prev = bus.bp_we;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vec_t j;
    int   n;
    bus.in_valid = 0; bus.pc_in = 0; bus.op_in = 0; bus.kind_in = 0;
    bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.opr1_in = 0; bus.opr2_in = 0; bus.imm_in = 0;
    bus.mem_e_in = 0; bus.wb_e_in = 0; bus.fwd_en = 0; bus.fwd_idx = 0; bus.fwd_val = 0;
    bus.flush = 0; bus.out_ready = 1; bus.redir_ready = 1;

    //                   kind   op       pc          rd     rs1    rs2    opr1          opr2          imm           wb mem fen    fidx            fval                     res           store         rv  rpc
    vecs.push_back(mk(K_ALU, OP_ADD,  32'h0,   5'd3,  5'd1, 5'd2, 32'd5,        32'd7,        32'd7,        1, 0, 2'b00, 10'd0,          64'd0,                   32'd12,       32'd7,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SUB,  32'h0,   5'd5,  5'd1, 5'd2, 32'd5,        32'd100,      32'd7,        1, 0, 2'b00, 10'd0,          64'd0,                   32'hFFFFFFFE, 32'd100,      0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_ADD,  32'h0,   5'd6,  5'd4, 5'd2, 32'd1,        32'd0,        32'd1,        1, 0, 2'b11, {5'd4, 5'd4},   {32'd200, 32'd100},      32'd101,      32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_ADD,  32'h0,   5'd6,  5'd0, 5'd0, 32'd1,        32'd9,        32'd1,        1, 0, 2'b11, {5'd0, 5'd0},   {32'd200, 32'd100},      32'd2,        32'd9,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SLL,  32'h0,   5'd8,  5'd1, 5'd6, 32'd1,        32'd3,        32'd31,       1, 0, 2'b11, {5'd6, 5'd5},   {32'h55, 32'h77},        32'h80000000, 32'h55,       0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SRA,  32'h0,   5'd9,  5'd1, 5'd2, 32'h80000000, 32'd0,        32'h24,       1, 0, 2'b00, 10'd0,          64'd0,                   32'hF8000000, 32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SRL,  32'h0,   5'd9,  5'd1, 5'd2, 32'h80000000, 32'd0,        32'h24,       1, 0, 2'b00, 10'd0,          64'd0,                   32'h08000000, 32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SLT,  32'h0,   5'd9,  5'd1, 5'd2, 32'hFFFFFFFF, 32'd0,        32'd1,        1, 0, 2'b00, 10'd0,          64'd0,                   32'd1,        32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_SLTU, 32'h0,   5'd9,  5'd1, 5'd2, 32'hFFFFFFFF, 32'd0,        32'd1,        1, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_XOR,  32'h0,   5'd9,  5'd1, 5'd2, 32'hF0F0,     32'd0,        32'h0FF0,     1, 0, 2'b00, 10'd0,          64'd0,                   32'hFF00,     32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_OR,   32'h0,   5'd9,  5'd1, 5'd2, 32'hF0F0,     32'd0,        32'h0FF0,     1, 0, 2'b00, 10'd0,          64'd0,                   32'hFFF0,     32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_AND,  32'h0,   5'd9,  5'd1, 5'd2, 32'hF0F0,     32'd0,        32'h0FF0,     1, 0, 2'b00, 10'd0,          64'd0,                   32'h00F0,     32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_MUL,  32'h0,   5'd7,  5'd1, 5'd2, 32'hFFFFFFFF, 32'd2,        32'd5,        1, 0, 2'b00, 10'd0,          64'd0,                   32'hFFFFFFFE, 32'd2,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_MUL,  32'h0,   5'd7,  5'd1, 5'd3, 32'h12345,    32'd0,        32'd0,        1, 0, 2'b01, {5'd0, 5'd3},   {32'd0, 32'h10000},      32'h23450000, 32'h10000,    0, 32'h0));
    vecs.push_back(mk(K_BR,  OP_EQ,   32'h40,  5'd0,  5'd1, 5'd2, 32'd9,        32'd9,        32'h10,       1, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'd9,        1, 32'h50));
    vecs.push_back(mk(K_BR,  OP_NE,   32'h40,  5'd0,  5'd1, 5'd2, 32'd9,        32'd9,        32'h10,       1, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'd9,        0, 32'h0));
    vecs.push_back(mk(K_BR,  OP_LT,   32'h100, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 0, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'd1,        1, 32'hF0));
    vecs.push_back(mk(K_BR,  OP_GE,   32'h104, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFF, 32'd1,        32'h20,       0, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'd1,        0, 32'h0));
    vecs.push_back(mk(K_BR,  OP_LTU,  32'h108, 5'd0,  5'd1, 5'd2, 32'd1,        32'hFFFFFFFF, 32'd8,        0, 0, 2'b00, 10'd0,          64'd0,                   32'd0,        32'hFFFFFFFF, 1, 32'h110));
    vecs.push_back(mk(K_JAL, OP_ADD,  32'h200, 5'd1,  5'd0, 5'd0, 32'd0,        32'd0,        32'h80,       1, 0, 2'b00, 10'd0,          64'd0,                   32'h204,      32'd0,        1, 32'h280));
    vecs.push_back(mk(K_ALU, OP_ADD,  32'h0,   5'd10, 5'd1, 5'd2, 32'h1000,     32'd0,        32'd4,        1, 1, 2'b00, 10'd0,          64'd0,                   32'h1004,     32'd0,        0, 32'h0));
    vecs.push_back(mk(K_ALU, OP_ADD,  32'h0,   5'd0,  5'd1, 5'd2, 32'd3,        32'd0,        32'd4,        1, 0, 2'b00, 10'd0,          64'd0,                   32'd7,        32'd0,        0, 32'h0));

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_redir_valid", bus.redir_valid, 1'b0);
    check("rst_bp_we", bus.bp_we, 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_fwd_idx", bus.ex_fwd_idx, 5'd0);
    rst = 1'b1;

    // Table: every op through the scoreboard, single-cycle ops checked for latency 1.
    foreach (vecs[i]) begin
      issue(vecs[i], i, 1'b1);
      if (!(vecs[i].kind == K_ALU && vecs[i].op == OP_MUL)) begin
        @(negedge clk);
        check($sformatf("v%0d_latency", i), bus.out_valid, 1'b1);
      end
    end

    // MUL occupancy: in_ready low for MUL_LAT cycles after accept.
    issue(vecs[12], 100, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", n, 3);

    // JALR with redirect stalled: result drains first, redirect held.
    j = mk(K_JALR, OP_ADD, 32'h20, 5'd1, 5'd5, 5'd0, 32'h101, 32'd0, 32'd4, 1, 0, 2'b00, 10'd0, 64'd0, 32'h24, 32'd0, 1, 32'h104);
    bus.redir_ready = 1'b0;
    issue(j, 200, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("jalr_redir_hold%0d", c), bus.redir_valid, 1'b1);
      check($sformatf("jalr_redir_pc%0d", c), bus.redir_pc, 32'h104);
      check($sformatf("jalr_in_ready%0d", c), bus.in_ready, 1'b0);
      if (c > 0) check($sformatf("jalr_out_done%0d", c), bus.out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.redir_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("jalr_in_ready_after", bus.in_ready, 1'b1);

    // JAL with result stalled: redirect drains first, result held stable.
    j = mk(K_JAL, OP_ADD, 32'h300, 5'd2, 5'd0, 5'd0, 32'd0, 32'd0, 32'h20, 1, 0, 2'b00, 10'd0, 64'd0, 32'h304, 32'd0, 1, 32'h320);
    bus.out_ready = 1'b0;
    issue(j, 300, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("jal_out_hold", bus.out_valid, 1'b1);
    check("jal_out_stable", bus.result, 32'h304);
    check("jal_redir_done", bus.redir_valid, 1'b0);
    check("jal_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("jal_in_ready_after", bus.in_ready, 1'b1);

    // Flush on the second cycle of a MUL while a new op is offered.
    issue(vecs[12], 400, 1'b0);
    bus.flush = 1'b1;
    bus.kind_in = K_ALU; bus.op_in = OP_ADD; bus.in_valid = 1'b1;
    @(negedge clk);
    check("flush_mul_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("flush_mul_no_out%0d", c), bus.out_valid, 1'b0);
      check($sformatf("flush_mul_ready%0d", c), bus.in_ready, 1'b1);
    end

    // Flush in IDLE beats a simultaneous in_valid.
    @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_no_accept", bus.out_valid, 1'b0);
    check("flush_idle_ready", bus.in_ready, 1'b1);

    // Flush in DONE with both handshakes pending.
    bus.out_ready = 1'b0;
    bus.redir_ready = 1'b0;
    issue(vecs[19], 500, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_out", bus.out_valid, 1'b0);
    check("flush_done_redir", bus.redir_valid, 1'b0);
    check("flush_done_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    bus.redir_ready = 1'b1;

    // Asynchronous reset mid-MUL, then recovery.
    issue(vecs[12], 600, 1'b0);
    rst = 1'b0;
    #2;
    check("rst_mul_ready", bus.in_ready, 1'b1);
    check("rst_mul_out", bus.out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    issue(vecs[0], 700, 1'b1);
    repeat (3) @(negedge clk);

    check("out_q_empty", out_q.size(), 0);
    check("redir_q_empty", redir_q.size(), 0);
    check("bp_q_empty", bp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
